// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one val/rdy memory port between the instruction-fetch
// requester (imem) and the data requester (dmem). Allows one outstanding
// transaction and routes each response back to whoever issued the request.
//
// Build option: define MEM_ARBITER_ROUND_ROBIN_EN to alternate the grant when
// both requesters contend. Left undefined, dmem always beats imem.
//
// state  | meaning
// IDLE   | nothing outstanding, arbitrating and presenting a request
// WAIT_I | fetch request accepted by memory, waiting for its response
// WAIT_D | data request accepted by memory, waiting for its response
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              imemreq_val,
  output logic              imemreq_rdy,
  input  logic [ADDR_W-1:0] imemreq_addr,
  output logic              imemresp_val,
  output logic [DATA_W-1:0] imemresp_data,

  input  logic              dmemreq_val,
  output logic              dmemreq_rdy,
  input  logic              dmemreq_type,
  input  logic [ADDR_W-1:0] dmemreq_addr,
  input  logic [DATA_W-1:0] dmemreq_wdata,
  output logic              dmemresp_val,
  output logic [DATA_W-1:0] dmemresp_data,

  output logic              memreq_val,
  input  logic              memreq_rdy,
  output logic              memreq_type,
  output logic [ADDR_W-1:0] memreq_addr,
  output logic [DATA_W-1:0] memreq_wdata,
  input  logic              memresp_val,
  input  logic [DATA_W-1:0] memresp_data,

  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t state;
  logic   err_q;
  logic   in_idle;
  logic   grant_d;
  logic   fire;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // 1 means dmem received the most recent grant; reset to imem so dmem takes the first tie
  logic   last_grant;

  // Grant selection: on a tie, favour whoever did not win last time
  always_comb begin
    if (dmemreq_val && imemreq_val) begin
      grant_d = ~last_grant;
    end else begin
      grant_d = dmemreq_val;
    end
  end
`else
  // Grant selection: fixed priority, dmem ahead of imem
  always_comb begin
    grant_d = dmemreq_val;
  end
`endif

  // Request mux, handshakes and response routing; all valids/readies held low during reset
  always_comb begin
    in_idle    = (state == IDLE) && !rst;
    memreq_val = in_idle && (imemreq_val || dmemreq_val);
    fire       = memreq_val && memreq_rdy;

    if (grant_d) begin
      memreq_type  = dmemreq_type;
      memreq_addr  = dmemreq_addr;
      memreq_wdata = dmemreq_wdata;
    end else begin
      memreq_type  = 1'b0;
      memreq_addr  = imemreq_addr;
      memreq_wdata = '0;
    end

    dmemreq_rdy = in_idle && dmemreq_val && grant_d && memreq_rdy;
    imemreq_rdy = in_idle && imemreq_val && !grant_d && memreq_rdy;

    // Response data is shared; only the owner's valid is raised
    imemresp_data = memresp_data;
    dmemresp_data = memresp_data;
    imemresp_val  = !rst && (state == WAIT_I) && memresp_val;
    dmemresp_val  = !rst && (state == WAIT_D) && memresp_val;

    busy = !rst && (state != IDLE);
    err  = err_q && !rst;
  end

  // Transaction sequencing, sticky error for orphan responses, tie-break history
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err_q <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A response with nothing outstanding (e.g. one orphaned by reset) is dropped
          if (memresp_val) begin
            err_q <= 1'b1;
          end
          if (fire) begin
            state <= grant_d ? WAIT_D : WAIT_I;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant <= grant_d;
`endif
          end
        end
        WAIT_I, WAIT_D: begin
          if (memresp_val) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the two requesters and the memory.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        imemreq_val, imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        dmemreq_val, dmemreq_rdy, dmemreq_type;
  logic [31:0] dmemreq_addr, dmemreq_wdata;
  logic        dmemresp_val;
  logic [31:0] dmemresp_data;
  logic        memreq_val, memreq_rdy, memreq_type;
  logic [31:0] memreq_addr, memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_data;
  logic        busy, err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val(dmemresp_val), .dmemresp_data(dmemresp_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
    .memresp_val(memresp_val), .memresp_data(memresp_data),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen 2 units later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imemreq_val = 1'b0; imemreq_addr = 32'h0;
    dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = 32'h0; dmemreq_wdata = 32'h0;
    memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_data = 32'h0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    imemreq_val = 1'b1; dmemreq_val = 1'b1; memreq_rdy = 1'b1; memresp_val = 1'b1;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      #2;
      checks++;
      if ({memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val, busy, err} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got val/rdy/busy/err=%b expected 0000000", c,
                 {memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val, busy, err});
      end
    end
    rst = 1'b0;
    clear_inputs();
    next_cycle();
    #2;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b err=%b expected 0 0", busy, err);
    end
  endtask

  task automatic test_single_fetch();
    imemreq_val = 1'b1; imemreq_addr = 32'h100; memreq_rdy = 1'b1;
    #2;
    checks++;
    if (memreq_val !== 1'b1 || memreq_addr !== 32'h100 || memreq_type !== 1'b0 ||
        imemreq_rdy !== 1'b1 || dmemreq_rdy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_req: val=%b addr=%h type=%b irdy=%b drdy=%b expected 1 100 0 1 0",
               memreq_val, memreq_addr, memreq_type, imemreq_rdy, dmemreq_rdy);
    end
    next_cycle();
    imemreq_val = 1'b0; memresp_val = 1'b1; memresp_data = 32'hDEADBEEF;
    #2;
    checks++;
    if (imemresp_val !== 1'b1 || imemresp_data !== 32'hDEADBEEF || dmemresp_val !== 1'b0 ||
        busy !== 1'b1 || memreq_val !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp: ival=%b data=%h dval=%b busy=%b mval=%b expected 1 deadbeef 0 1 0",
               imemresp_val, imemresp_data, dmemresp_val, busy, memreq_val);
    end
    next_cycle();
    memresp_val = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_contention();
    bit exp_d;
    imemreq_val = 1'b1; imemreq_addr = 32'h200;
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h300; dmemreq_wdata = 32'h5;
    memreq_rdy = 1'b1;
    #2;
    checks++;
    if (memreq_type !== 1'b1 || memreq_addr !== 32'h300 || memreq_wdata !== 32'h5 ||
        dmemreq_rdy !== 1'b1 || imemreq_rdy !== 1'b0) begin
      errors++;
      $display("FAIL contention_dwin: type=%b addr=%h wdata=%h drdy=%b irdy=%b expected 1 300 5 1 0",
               memreq_type, memreq_addr, memreq_wdata, dmemreq_rdy, imemreq_rdy);
    end
    next_cycle();
    dmemreq_val = 1'b0; memresp_val = 1'b1; memresp_data = 32'h0;
    #2;
    checks++;
    if (dmemresp_val !== 1'b1 || imemresp_val !== 1'b0) begin
      errors++;
      $display("FAIL write_ack: dval=%b ival=%b expected 1 0", dmemresp_val, imemresp_val);
    end
    next_cycle();
    memresp_val = 1'b0;
    #2;
    checks++;
    if (memreq_addr !== 32'h200 || memreq_type !== 1'b0 || imemreq_rdy !== 1'b1) begin
      errors++;
      $display("FAIL contention_ifollow: addr=%h type=%b irdy=%b expected 200 0 1",
               memreq_addr, memreq_type, imemreq_rdy);
    end
    next_cycle();
    imemreq_val = 1'b0; memresp_val = 1'b1;
    next_cycle();
    memresp_val = 1'b0;
    // Sustained contention: last winner was imem, so the sequence starts with dmem
    for (int k = 0; k < 4; k++) begin
      imemreq_val = 1'b1; dmemreq_val = 1'b1; memreq_rdy = 1'b1; memresp_val = 1'b0;
      exp_d = RR ? (k % 2 == 0) : 1'b1;
      #2;
      checks++;
      if (dmemreq_rdy !== exp_d || imemreq_rdy !== !exp_d) begin
        errors++;
        $display("FAIL contention_seq[%0d]: drdy=%b irdy=%b expected %b %b",
                 k, dmemreq_rdy, imemreq_rdy, exp_d, !exp_d);
      end
      next_cycle();
      memresp_val = 1'b1;
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_backpressure();
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h40; memreq_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (memreq_val !== 1'b1 || dmemreq_rdy !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: mval=%b drdy=%b busy=%b expected 1 0 0",
                 c, memreq_val, dmemreq_rdy, busy);
      end
      next_cycle();
    end
    memreq_rdy = 1'b1;
    #2;
    checks++;
    if (dmemreq_rdy !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: drdy=%b expected 1", dmemreq_rdy);
    end
    next_cycle();
    dmemreq_val = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b1 || memreq_val !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_wait: busy=%b mval=%b expected 1 0", busy, memreq_val);
    end
    memresp_val = 1'b1; memresp_data = 32'h1234;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random(int n);
    int          outst;   // 0 none, 1 fetch owner, 2 data owner
    int          dly;
    bit          i_pend, d_pend, d_type, win_d, last_d, exp_val;
    logic [31:0] i_addr, d_addr, d_wdata, exp_addr, exp_wdata;
    logic        exp_type;
    pulse_reset();
    outst = 0; dly = 0; i_pend = 0; d_pend = 0; last_d = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_type = 1'b0;
    for (int c = 0; c < n; c++) begin
      next_cycle();
      memresp_val = 1'b0;
      memresp_data = $urandom;
      if (outst != 0) begin
        if (dly == 0) memresp_val = 1'b1;
        else dly--;
      end
      memreq_rdy = ($urandom_range(0, 3) != 0);
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; i_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_type = 1'($urandom_range(0, 1));
      end
      imemreq_val = i_pend; imemreq_addr = i_addr;
      dmemreq_val = d_pend; dmemreq_addr = d_addr; dmemreq_wdata = d_wdata; dmemreq_type = d_type;
      #2;
      if (outst == 0) begin
        if (i_pend && d_pend) win_d = RR ? !last_d : 1'b1;
        else win_d = d_pend;
        exp_val = i_pend || d_pend;
        checks++;
        if (memreq_val !== exp_val || imemreq_rdy !== (exp_val && !win_d && memreq_rdy) ||
            dmemreq_rdy !== (exp_val && win_d && memreq_rdy) || busy !== 1'b0 ||
            imemresp_val !== 1'b0 || dmemresp_val !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle[%0d]: mval=%b irdy=%b drdy=%b busy=%b ival=%b dval=%b expected %b %b %b 0 0 0",
                   c, memreq_val, imemreq_rdy, dmemreq_rdy, busy, imemresp_val, dmemresp_val,
                   exp_val, exp_val && !win_d && memreq_rdy, exp_val && win_d && memreq_rdy);
        end
        if (exp_val) begin
          exp_addr  = win_d ? d_addr : i_addr;
          exp_type  = win_d ? d_type : 1'b0;
          exp_wdata = win_d ? d_wdata : 32'h0;
          checks++;
          if (memreq_addr !== exp_addr || memreq_type !== exp_type || memreq_wdata !== exp_wdata) begin
            errors++;
            $display("FAIL rand_fields[%0d]: addr=%h type=%b wdata=%h expected %h %b %h",
                     c, memreq_addr, memreq_type, memreq_wdata, exp_addr, exp_type, exp_wdata);
          end
          if (memreq_rdy) begin
            outst = win_d ? 2 : 1;
            dly = $urandom_range(0, 2);
            if (win_d) d_pend = 1'b0;
            else i_pend = 1'b0;
            last_d = win_d;
          end
        end
      end else begin
        checks++;
        if (memreq_val !== 1'b0 || imemreq_rdy !== 1'b0 || dmemreq_rdy !== 1'b0 || busy !== 1'b1 ||
            imemresp_val !== (outst == 1 && memresp_val) || dmemresp_val !== (outst == 2 && memresp_val)) begin
          errors++;
          $display("FAIL rand_wait[%0d]: mval=%b irdy=%b drdy=%b busy=%b ival=%b dval=%b owner=%0d resp=%b",
                   c, memreq_val, imemreq_rdy, dmemreq_rdy, busy, imemresp_val, dmemresp_val,
                   outst, memresp_val);
        end
        if (memresp_val) begin
          checks++;
          if (imemresp_data !== memresp_data || dmemresp_data !== memresp_data) begin
            errors++;
            $display("FAIL rand_rdata[%0d]: idata=%h ddata=%h expected %h",
                     c, imemresp_data, dmemresp_data, memresp_data);
          end
          outst = 0;
        end
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rand_no_err: err=%b expected 0", err);
    end
    pulse_reset();
  endtask

  task automatic test_spurious();
    memresp_val = 1'b1; memresp_data = 32'hCAFE0000;
    #2;
    checks++;
    if (imemresp_val !== 1'b0 || dmemresp_val !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL spurious_same: ival=%b dval=%b err=%b expected 0 0 0",
               imemresp_val, dmemresp_val, err);
    end
    next_cycle();
    memresp_val = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL spurious_sticky[%0d]: err=%b expected 1", c, err);
      end
      next_cycle();
    end
    pulse_reset();
    #2;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL spurious_cleared: err=%b expected 0", err);
    end
  endtask

  task automatic test_reset_mid_op();
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h80; memreq_rdy = 1'b1;
    #2;
    checks++;
    if (dmemreq_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midop_fire: drdy=%b expected 1", dmemreq_rdy);
    end
    next_cycle();
    dmemreq_val = 1'b0; rst = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_rst_busy: busy=%b expected 0", busy);
    end
    next_cycle();
    rst = 1'b0; memresp_val = 1'b1; memresp_data = 32'h77;
    #2;
    checks++;
    if (dmemresp_val !== 1'b0 || imemresp_val !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_late_resp: dval=%b ival=%b busy=%b expected 0 0 0",
               dmemresp_val, imemresp_val, busy);
    end
    next_cycle();
    memresp_val = 1'b0;
    #2;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL midop_err: err=%b expected 1", err);
    end
    pulse_reset();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_contention();
    test_backpressure();
    test_random(2000);
    test_spurious();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
